// File: rtl/sramx_mem_responder.sv
// rtl/sramx_mem_responder.sv - sramx responder: word memory with fixed-latency in-order response queue
// Accepts one request per cycle and returns data_ok LATENCY cycles after the accept edge.
module sramx_mem_responder #(
  parameter int AW      = 10,
  parameter int LATENCY = 2,
  parameter int QDEPTH  = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic [31:0] rdata,
  output logic        data_ok
);

  localparam int PW    = $clog2(QDEPTH);
  localparam int CW    = 4;
  localparam int DEPTH = 1 << AW;

  logic [31:0]   mem    [DEPTH];
  logic [31:0]   q_data [QDEPTH];
  logic [CW-1:0] q_cnt  [QDEPTH];
  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          pop, full, accept;
  logic [AW-1:0] idx;
  logic [3:0]    be;
  logic          unused_addr;

  assign idx         = addr[AW+1:2];
  assign unused_addr = ^addr[31:AW+2];

  always_comb begin
    be = 4'b1111;
    case (size)
      2'd0:    be = 4'b0001 << addr[1:0];
      2'd1:    be = addr[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // A pop in the same cycle frees the slot that a push may then reuse.
  assign pop     = !reset && (count != '0) && (q_cnt[head] == '0);
  assign full    = (count == (PW+1)'(QDEPTH)) && !pop;
  assign addr_ok = req && !reset && !full;
  assign accept  = addr_ok;
  assign data_ok = pop;
  assign rdata   = pop ? q_data[head] : 32'h0;

  // Memory and queue payload are intentionally left unreset.
  always_ff @(posedge clk) begin
    if (accept && wr) begin
      for (int j = 0; j < 4; j++) begin
        if (be[j]) mem[idx][8*j +: 8] <= wdata[8*j +: 8];
      end
    end
    if (accept) q_data[tail] <= wr ? 32'h0 : mem[idx];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < QDEPTH; i++) q_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < QDEPTH; i++) begin
        if (accept && (tail == PW'(i))) q_cnt[i] <= CW'(LATENCY - 1);
        else if (q_cnt[i] != '0)        q_cnt[i] <= q_cnt[i] - CW'(1);
      end
      if (pop)    head <= head + PW'(1);
      if (accept) tail <= tail + PW'(1);
      case ({accept, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_sramx_mem_responder.sv
// tb/tb_sramx_mem_responder.sv - self-checking bench for sramx_mem_responder
// Two instances: a (QDEPTH=4, LATENCY=2) and b (QDEPTH=2, LATENCY=4), checked against a queue model.
module tb_sramx_mem_responder;

  logic        clk = 0;
  logic        reset = 1;
  logic [1:0]  req = '0;
  logic [1:0]  wr_v = '0;
  logic [1:0]  size_v [2];
  logic [31:0] addr_v [2];
  logic [31:0] wdata_v [2];
  logic [1:0]  addr_ok;
  logic [1:0]  data_ok;
  logic [31:0] rdata [2];

  int checks = 0;
  int failures = 0;
  int stalls [2];
  int cyc = 0;

  typedef struct { int d; int due; logic [31:0] data; } ent_t;
  ent_t        mq[$];
  logic [31:0] mmem [2][1024];
  logic [31:0] log0[$];
  logic [31:0] log1[$];

  localparam int LAT [2] = '{2, 4};
  localparam int QD  [2] = '{4, 2};

  always #5 clk = ~clk;

  sramx_mem_responder #(.AW(10), .LATENCY(2), .QDEPTH(4)) dut_a (
    .clk(clk), .reset(reset), .req(req[0]), .wr(wr_v[0]), .size(size_v[0]),
    .addr(addr_v[0]), .wdata(wdata_v[0]), .addr_ok(addr_ok[0]),
    .rdata(rdata[0]), .data_ok(data_ok[0]));

  sramx_mem_responder #(.AW(10), .LATENCY(4), .QDEPTH(2)) dut_b (
    .clk(clk), .reset(reset), .req(req[1]), .wr(wr_v[1]), .size(size_v[1]),
    .addr(addr_v[1]), .wdata(wdata_v[1]), .addr_ok(addr_ok[1]),
    .rdata(rdata[1]), .data_ok(data_ok[1]));

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s t=%0t actual=%h expected=%h", name, $time, act, exp);
    end
  endfunction

  function automatic logic [3:0] lanes(input logic [1:0] sz, input logic [31:0] a);
    if (sz == 2'd0) return 4'b0001 << a[1:0];
    if (sz == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // Model: expected outputs and state update, evaluated mid-cycle when inputs are stable.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      int hi, n;
      bit pop, acc;
      logic [3:0] be;
      hi = -1; n = 0;
      for (int k = 0; k < mq.size(); k++) begin
        if (mq[k].d == d) begin
          if (hi < 0) hi = k;
          n++;
        end
      end
      if (data_ok[d]) begin
        if (d == 0) log0.push_back(rdata[d]); else log1.push_back(rdata[d]);
      end
      if (reset) begin
        check(d ? "b_addr_ok_rst" : "a_addr_ok_rst", {31'b0, addr_ok[d]}, 32'd0);
        check(d ? "b_data_ok_rst" : "a_data_ok_rst", {31'b0, data_ok[d]}, 32'd0);
        check(d ? "b_rdata_rst" : "a_rdata_rst", rdata[d], 32'h0);
        for (int k = mq.size() - 1; k >= 0; k--) if (mq[k].d == d) mq.delete(k);
      end else begin
        pop = (hi >= 0) && (mq[hi].due == cyc);
        acc = req[d] && !((n == QD[d]) && !pop);
        check(d ? "b_data_ok" : "a_data_ok", {31'b0, data_ok[d]}, {31'b0, pop});
        check(d ? "b_rdata" : "a_rdata", rdata[d], pop ? mq[hi].data : 32'h0);
        check(d ? "b_addr_ok" : "a_addr_ok", {31'b0, addr_ok[d]}, {31'b0, acc});
        if (pop) mq.delete(hi);
        if (acc) begin
          ent_t e;
          e.d = d; e.due = cyc + LAT[d];
          e.data = wr_v[d] ? 32'h0 : mmem[d][addr_v[d][11:2]];
          if (wr_v[d]) begin
            be = lanes(size_v[d], addr_v[d]);
            for (int j = 0; j < 4; j++)
              if (be[j]) mmem[d][addr_v[d][11:2]][8*j +: 8] = wdata_v[d][8*j +: 8];
          end
          mq.push_back(e);
        end
      end
    end
  end

  task automatic issue(input int d, input bit w, input logic [1:0] sz,
                       input logic [31:0] a, input logic [31:0] wd);
    int n;
    bit got;
    req[d] = 1'b1; wr_v[d] = w; size_v[d] = sz; addr_v[d] = a; wdata_v[d] = wd;
    got = 0; n = 0;
    while (!got && n < 40) begin
      @(negedge clk);
      if (addr_ok[d]) got = 1; else stalls[d]++;
      n++;
    end
    @(posedge clk); #1;
    req[d] = 1'b0;
    if (!got) begin
      checks++; failures++;
      $display("FAIL issue_timeout dut=%0d addr=%h actual=no_accept expected=accept", d, a);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      size_v[d] = 2'd2; addr_v[d] = '0; wdata_v[d] = '0; stalls[d] = 0;
    end
    req[0] = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_addr_ok_lit", {31'b0, addr_ok[0]}, 32'd0);
    check("reset_data_ok_lit", {31'b0, data_ok[0]}, 32'd0);
    @(posedge clk); #1;
    req[0] = 1'b0;
    reset = 1'b0;
    idle(2);

    // Word write then read next cycle
    log0.delete();
    issue(0, 1, 2'd2, 32'h0000_0010, 32'hDEAD_BEEF);
    issue(0, 0, 2'd2, 32'h0000_0010, 32'h0);
    idle(4);
    check("t1_log_size", log0.size(), 32'd2);
    if (log0.size() == 2) begin
      check("t1_write_resp", log0[0], 32'h0);
      check("t1_read_resp", log0[1], 32'hDEAD_BEEF);
    end

    // Byte and half lanes
    log0.delete();
    issue(0, 1, 2'd2, 32'h0000_0020, 32'h1122_3344);
    issue(0, 1, 2'd0, 32'h0000_0021, 32'h0000_AA00);
    issue(0, 1, 2'd1, 32'h0000_0022, 32'hBEEF_0000);
    issue(0, 0, 2'd2, 32'h0000_0020, 32'h0);
    idle(4);
    check("t2_log_size", log0.size(), 32'd4);
    if (log0.size() == 4) check("t2_lanes", log0[3], 32'hBEEF_AA44);

    // Back-to-back reads at full throughput
    for (int i = 0; i < 8; i++) issue(0, 1, 2'd2, 32'h100 + 4*i, 32'hA000_0000 + i);
    idle(4);
    log0.delete(); stalls[0] = 0;
    for (int i = 0; i < 8; i++) issue(0, 0, 2'd2, 32'h100 + 4*i, 32'h0);
    idle(4);
    check("t3_stalls", stalls[0], 32'd0);
    check("t3_log_size", log0.size(), 32'd8);
    for (int i = 0; i < 8 && i < log0.size(); i++) check("t3_order", log0[i], 32'hA000_0000 + i);

    // Backpressure on the shallow instance
    for (int i = 0; i < 4; i++) issue(1, 1, 2'd2, 32'h40 + 4*i, 32'hB000_0000 + i);
    idle(8);
    log1.delete(); stalls[1] = 0;
    for (int i = 0; i < 4; i++) issue(1, 0, 2'd2, 32'h40 + 4*i, 32'h0);
    idle(8);
    check("t4_stalls", stalls[1], 32'd2);
    check("t4_log_size", log1.size(), 32'd4);
    for (int i = 0; i < 4 && i < log1.size(); i++) check("t4_order", log1[i], 32'hB000_0000 + i);

    // Reset with two reads outstanding
    log0.delete();
    issue(0, 0, 2'd2, 32'h0000_0010, 32'h0);
    issue(0, 0, 2'd2, 32'h0000_0020, 32'h0);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(5);
    check("t5_dropped", log0.size(), 32'd0);
    issue(0, 0, 2'd2, 32'h0000_0010, 32'h0);
    idle(4);
    check("t5_after_size", log0.size(), 32'd1);
    if (log0.size() == 1) check("t5_after_data", log0[0], 32'hDEAD_BEEF);

    // Address aliasing above AW+1, size 3 treated as word
    log0.delete();
    issue(0, 1, 2'd3, 32'h0000_1004, 32'h1234_5678);
    issue(0, 0, 2'd2, 32'h0000_0004, 32'h0);
    idle(4);
    check("t6_log_size", log0.size(), 32'd2);
    if (log0.size() == 2) check("t6_alias", log0[1], 32'h1234_5678);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sramx_mem_responder.md
Name: sramx_mem_responder

Overview:
Responder end of the SRAM-like (sramx) bus. CPU-side initiators issue requests on physical addresses after kseg0/kseg1 translation, and this block serves them. It wraps a word-organised on-chip memory, accepts at most one request per cycle with an addr_ok handshake, and returns responses strictly in order with data_ok after a fixed latency. It is used as the simulation and FPGA backing store behind the instruction and data ports.

Parameters:
AW, 10, log2 of memory depth in 32-bit words; index = addr[AW+1:2]
LATENCY, 2, cycles from accept edge to data_ok; legal range 1..8
QDEPTH, 4, outstanding-request queue entries; power of two, >= 2

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
req  input  1  request valid
wr  input  1  1 = write, 0 = read
size  input  2  0 = byte, 1 = half, 2 = word, 3 = treated as word
addr  input  32  physical byte address
wdata  input  32  write data, lane-positioned by the initiator
addr_ok  output  1  request accepted this cycle (req & addr_ok)
rdata  output  32  read word, valid while data_ok
data_ok  output  1  one in-order response completes this cycle

Behaviour:
- Clock and reset: single clock; reset is synchronous, active-high.
- Accept: a request is accepted on a rising edge where req and addr_ok are both 1.
- addr_ok = req & !reset & (queue not full). The queue counts as full when it holds QDEPTH entries and no pop occurs this cycle. A simultaneous pop frees a slot in the same cycle.
- Byte enables, computed from size and addr[1:0]:
  - byte: lane addr[1:0]
  - half: lanes {addr[1],0} and {addr[1],1}; addr[0] ignored
  - word or size 3: all lanes; addr[1:0] ignored
- Upper address bits above AW+1 are ignored; the memory aliases.
- Write: the memory array updates at the accept edge with the enabled lanes of wdata. The block enqueues an entry with is_write=1.
- Read: the full word at the index is sampled at the accept edge (value after any earlier write). The block enqueues an entry holding that word. rdata always returns the full word; the initiator extracts lanes.
- Ordering: a read accepted the cycle after a write to the same word returns the new data. Only one request is accepted per cycle, so there is no same-edge hazard.
- Entry timer:
  - Each entry carries a countdown loaded with LATENCY-1 at accept and decremented every cycle while nonzero.
  - The head entry pops when its countdown is 0.
  - The pop cycle drives data_ok=1.
  - rdata = stored word for reads and 32'h0 for writes.
- Latency and throughput:
  - Accept on edge N gives data_ok high in the cycle after edge N+LATENCY-1.
  - LATENCY=1 means data_ok in the cycle immediately after the accept edge.
  - With QDEPTH >= LATENCY, back-to-back accepts sustain one response per cycle.
  - With QDEPTH < LATENCY, addr_ok drops while the queue is full.
- At most one data_ok per cycle. Responses are in accept order and never reordered.
- Queue: circular buffer with head and tail pointers of log2(QDEPTH) bits that wrap modulo QDEPTH, plus a count of log2(QDEPTH)+1 bits. Simultaneous push and pop leaves the count unchanged.
- Reset values: queue emptied, pointers and count = 0, data_ok=0, rdata=0, addr_ok=0.
- Memory contents are not reset.
- Reset mid-operation: all outstanding responses are dropped with no data_ok. A write already accepted before reset stays committed.

Test Plan:
- Word write then read, LATENCY=2: write addr 0x00000010 data 0xDEADBEEF size 2, then read the same address the next cycle -> both addr_ok=1. Write data_ok with rdata=0 one cycle before the read's data_ok; read data_ok returns rdata=0xDEADBEEF; data_ok exactly 2 cycles after each accept.
- Byte and half lanes: prefill 0x11223344 at 0x20. Write byte 0xAA at 0x21 (wdata 0x0000AA00), then half 0xBEEF at 0x22 (wdata 0xBEEF0000), then read word 0x20 -> rdata=0xBEEFAA44.
- Back-to-back reads, QDEPTH=4, LATENCY=2: 8 consecutive reads with req held -> addr_ok stays 1 throughout; 8 consecutive data_ok cycles in address order.
- Backpressure, QDEPTH=2, LATENCY=4: 4 reads issued back to back -> addr_ok=0 once 2 entries are outstanding; all 4 responses arrive in order with no loss or duplication.
- Reset mid-flight: accept 2 reads, assert reset for 1 cycle before any data_ok -> no data_ok afterwards; queue empty; next request accepted normally.
- Aliasing with AW=10: write 0x12345678 at 0x00001004, read 0x00000004 -> rdata=0x12345678.
